// File: rtl/cpu_pkg.sv
// Shared loader definitions: FSM state encoding and stream framing constants.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR,
        ST_VERIFY_RD,
        ST_VERIFY_CMP
    } ldr_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from accepted stream bytes; word_valid marks
// the byte that completes a word, so the new word is on `word` the next cycle.
module byte_packer
    import cpu_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [BYTE_W-1:0]            in_byte,
    output logic [WORD_BYTES*BYTE_W-1:0] word,
    output logic                         word_valid
);

    localparam int CNT_W = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    assign word_valid = in_valid && (cnt == CNT_LAST);

    // Shift from the top so the first byte of a word lands in the LSBs.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (in_valid) begin
            word <= {in_byte, word[WORD_BYTES*BYTE_W-1:BYTE_W]};
            cnt  <= word_valid ? '0 : cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program image into CPU instruction memory, then
// enables the CPU. Define PROG_LOADER_READBACK_EN to verify the image by readback.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);

    localparam int IDX_W  = $clog2(IMEM_WORDS) + 1;
    localparam int WORD_W = WORD_BYTES * BYTE_W;
    localparam int HDR_W  = HDR_BYTES * BYTE_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    ldr_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  n_words;
    logic [BYTE_W-1:0] n_lo;
    logic [HDR_W-1:0]  hdr_n;
    logic              hdr_ok;
    logic              can_start;
    logic              last_word;
    logic [WORD_W-1:0] pk_word;
    logic              pk_word_valid;

    assign s_ready   = s_valid && (state == ST_HDR0 || state == ST_HDR1 || state == ST_COLLECT);
    assign hdr_n     = {s_data, n_lo};
    assign hdr_ok    = (hdr_n != '0) && (32'(hdr_n) <= IMEM_WORDS);
    assign can_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign last_word = (idx == n_words - IDX_ONE);
    assign addr_ext  = 64'({idx, 2'b00});
    assign wdata_ext = pk_word;

    byte_packer #(.BYTE_W(BYTE_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (can_start),
        .in_valid   (s_ready && state == ST_COLLECT),
        .in_byte    (s_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

`ifdef PROG_LOADER_READBACK_EN
    logic [WORD_W-1:0] shadow [IMEM_WORDS];

    always_ff @(posedge clk) begin
        if (state == ST_WRITE) shadow[idx[IDX_W-2:0]] <= pk_word;
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n_words    <= '0;
            n_lo       <= '0;
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            cpu_enable <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wen_ext <= 1'b0;
            ren_ext <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_HDR0;
                        idx        <= '0;
                        cpu_enable <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (s_ready) begin
                        n_lo  <= s_data;
                        state <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (s_ready) begin
                        if (hdr_ok) begin
                            n_words <= IDX_W'(hdr_n);
                            state   <= ST_COLLECT;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (pk_word_valid) begin
                        state   <= ST_WRITE;
                        wen_ext <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
`ifdef PROG_LOADER_READBACK_EN
                        idx     <= '0;
                        ren_ext <= 1'b1;
                        state   <= ST_VERIFY_RD;
`else
                        state      <= ST_DONE;
                        cpu_enable <= 1'b1;
                        busy       <= 1'b0;
`endif
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= ST_COLLECT;
                    end
                end
`ifdef PROG_LOADER_READBACK_EN
                // Memory returns the word one cycle after the read strobe.
                ST_VERIFY_RD: state <= ST_VERIFY_CMP;
                ST_VERIFY_CMP: begin
                    if (rdata_ext != shadow[idx[IDX_W-2:0]]) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (last_word) begin
                        state      <= ST_DONE;
                        cpu_enable <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        idx     <= idx + IDX_ONE;
                        ren_ext <= 1'b1;
                        state   <= ST_VERIFY_RD;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-count reference model checked every
// cycle, plus literal expectations for the documented load scenarios.
module tb_prog_loader;

    localparam int IMEM_WORDS = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext = 32'h0;
    logic        cpu_enable, busy, error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prog_loader #(.IMEM_WORDS(IMEM_WORDS), .BYTE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    // Instruction memory behind the external port; optional single-bit corruption of word 1.
    logic [31:0] mem [IMEM_WORDS];
    bit          corrupt = 1'b0;
    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^ ((corrupt && addr_ext[10:2] == 9'd1) ? 32'h1 : 32'h0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks load progress as a count of accepted bytes.
    bit          m_active, m_wr, m_done, m_err, m_ver, m_vcmp;
    int          m_nb, m_n, m_widx, m_vidx;
    logic [7:0]  m_lo;
    logic [31:0] m_words [IMEM_WORDS];
    logic [63:0] wl_addr[$];
    logic [31:0] wl_data[$];

    initial begin
        int p, w, k;
        forever begin
            @(negedge clk);
            check("s_ready", s_ready, m_active && !m_wr && !m_ver && s_valid);
            check("busy", busy, m_active);
            check("cpu_enable", cpu_enable, m_done);
            check("error", error, m_err);
            check("wen_ext", wen_ext, m_wr);
            check("ren_ext", ren_ext, m_ver && !m_vcmp);
            if (m_wr) begin
                check("wr_addr", addr_ext, m_widx * 4);
                check("wr_data", wdata_ext, m_words[m_widx]);
            end
            if (m_ver && !m_vcmp) check("rd_addr", addr_ext, m_vidx * 4);
            if (wen_ext === 1'b1) begin
                wl_addr.push_back(addr_ext);
                wl_data.push_back(wdata_ext);
            end
            if (rst) begin
                m_active = 0; m_wr = 0; m_done = 0; m_err = 0; m_ver = 0; m_vcmp = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1; m_done = 0; m_err = 0; m_nb = 0;
                end
            end else if (m_wr) begin
                m_wr = 0;
                if (m_widx == m_n - 1) begin
`ifdef PROG_LOADER_READBACK_EN
                    m_ver = 1; m_vcmp = 0; m_vidx = 0;
`else
                    m_active = 0; m_done = 1;
`endif
                end
            end else if (m_ver) begin
                if (!m_vcmp) m_vcmp = 1;
                else begin
                    m_vcmp = 0;
                    if (rdata_ext !== m_words[m_vidx]) begin
                        m_ver = 0; m_active = 0; m_err = 1;
                    end else if (m_vidx == m_n - 1) begin
                        m_ver = 0; m_active = 0; m_done = 1;
                    end else m_vidx++;
                end
            end else if (s_valid) begin
                m_nb++;
                if (m_nb == 1) m_lo = s_data;
                else if (m_nb == 2) begin
                    m_n = int'({s_data, m_lo});
                    if (m_n < 1 || m_n > IMEM_WORDS) begin
                        m_active = 0; m_err = 1;
                    end
                end else begin
                    p = m_nb - 3; w = p / 4; k = p % 4;
                    if (k == 0) m_words[w] = 32'h0;
                    m_words[w][8*k +: 8] = s_data;
                    if (k == 3) begin
                        m_wr = 1; m_widx = w;
                    end
                end
            end
        end
    end

    logic [7:0] stream[$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic build_stream(input int n, input int nwords);
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        for (int i = 0; i < nwords * 4; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [31:0] sword(input int i);
        return {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        bit acc = 1'b0;
        s_valid = 1'b1; s_data = b;
        do begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1; t++;
        end while (!acc && t < 64);
        s_valid = 1'b0;
        if (!acc) check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic send(input int first, input int count, input int max_gap, input bit inj_start);
        for (int i = first; i < first + count; i++) begin
            int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                if (inj_start && $urandom_range(0, 2) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            push_byte(stream[i]);
        end
    endtask

    task automatic wait_not_busy();
        int t = 0;
        while (busy && t < 5000) begin tick(); t++; end
        check("busy_timeout", busy, 1'b0);
        tick(); tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cpu_enable"}, cpu_enable, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_wen"}, wen_ext, 1'b0);
        check({tag, "_ren"}, ren_ext, 1'b0);
        check({tag, "_addr"}, addr_ext, 64'h0);
        check({tag, "_wdata"}, wdata_ext, 32'h0);
        check({tag, "_s_ready"}, s_ready, 1'b0);
    endtask

    task automatic full_load(input int n, input int max_gap, input bit inj_start);
        wl_addr.delete(); wl_data.delete();
        pulse_start();
        send(0, stream.size(), max_gap, inj_start);
        wait_not_busy();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ref_a[$];
        logic [31:0] ref_d[$];
        int n;

        tick(); tick();
        rst = 1'b0;
        check_idle_outputs("reset");

        // Two-word program, gap-free.
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        full_load(2, 0, 0);
        check("two_word_count", wl_addr.size(), 2);
        if (wl_addr.size() == 2) begin
            check("two_word_a0", wl_addr[0], 64'h0);
            check("two_word_d0", wl_data[0], 32'h00000513);
            check("two_word_a1", wl_addr[1], 64'h4);
            check("two_word_d1", wl_data[1], 32'h00100593);
        end
        check("two_word_cpu_enable", cpu_enable, 1'b1);
        check("two_word_error", error, 1'b0);

        // Zero-length header.
        build_stream(0, 0);
        full_load(0, 0, 0);
        check("n0_error", error, 1'b1);
        check("n0_cpu_enable", cpu_enable, 1'b0);
        check("n0_writes", wl_addr.size(), 0);

        // One word over capacity.
        build_stream(513, 0);
        full_load(513, 0, 0);
        check("n513_error", error, 1'b1);
        check("n513_writes", wl_addr.size(), 0);

        // Full-capacity image.
        build_stream(512, 512);
        full_load(512, 0, 0);
        check("n512_error", error, 1'b0);
        check("n512_cpu_enable", cpu_enable, 1'b1);
        check("n512_count", wl_addr.size(), 512);
        if (wl_addr.size() == 512) begin
            check("n512_last_addr", wl_addr[511], 64'h7FC);
            check("n512_last_data", wl_data[511], sword(511));
        end

        // Reset after the third byte of word 1, then a clean reload.
        build_stream(3, 3);
        wl_addr.delete(); wl_data.delete();
        pulse_start();
        send(0, 2 + 4 + 3, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle_outputs("midrst");
        full_load(3, 0, 0);
        check("reload_count", wl_addr.size(), 3);
        for (int i = 0; i < wl_addr.size() && i < 3; i++) begin
            check("reload_addr", wl_addr[i], 64'(i * 4));
            check("reload_data", wl_data[i], sword(i));
        end
        check("reload_cpu_enable", cpu_enable, 1'b1);

        // Random images: gapped stream with stray start pulses must match gap-free writes.
        repeat (4) begin
            n = $urandom_range(1, 12);
            build_stream(n, n);
            full_load(n, 0, 0);
            ref_a = wl_addr; ref_d = wl_data;
            check("rand_ref_count", ref_a.size(), n);
            for (int i = 0; i < ref_d.size() && i < n; i++) check("rand_ref_data", ref_d[i], sword(i));
            full_load(n, 5, 1);
            check("rand_gap_count", wl_addr.size(), ref_a.size());
            for (int i = 0; i < wl_addr.size() && i < ref_a.size(); i++) begin
                check("rand_gap_addr", wl_addr[i], ref_a[i]);
                check("rand_gap_data", wl_data[i], ref_d[i]);
            end
            check("rand_cpu_enable", cpu_enable, 1'b1);
        end

`ifdef PROG_LOADER_READBACK_EN
        // Corrupted readback of word 1.
        corrupt = 1'b1;
        build_stream(3, 3);
        full_load(3, 0, 0);
        check("rb_error", error, 1'b1);
        check("rb_cpu_enable", cpu_enable, 1'b0);
        check("rb_writes", wl_addr.size(), 3);
        corrupt = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
